// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode encoding and arbiter FSM states
package alu_pkg;
    localparam int WIDTH = 32;
    localparam int OP_W  = 5;
    localparam logic [OP_W-1:0]
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_SLL  = 5'b00010,
        ALU_SLTS = 5'b00011,
        ALU_SLTU = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_OR   = 5'b01001,
        ALU_AND  = 5'b01010,
        ALU_EQ   = 5'b10000,
        ALU_NE   = 5'b10001,
        ALU_LTS  = 5'b10010,
        ALU_GES  = 5'b10011,
        ALU_LTU  = 5'b10100,
        ALU_GEU  = 5'b10101;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_top.sv
// alu_top: combinational 32-bit ALU core; arithmetic ops drive result, compare ops drive flag
module alu_top
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             flag
);
    logic [WIDTH-1:0] one;
    assign one = {{(WIDTH-1){1'b0}}, 1'b1};
    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLTS: result = ($signed(a) < $signed(b)) ? one : '0;
            ALU_SLTU: result = (a < b) ? one : '0;
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_EQ:   flag = a == b;
            ALU_NE:   flag = a != b;
            ALU_LTS:  flag = $signed(a) < $signed(b);
            ALU_GES:  flag = $signed(a) >= $signed(b);
            ALU_LTU:  flag = a < b;
            ALU_GEU:  flag = a >= b;
            default:  ;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one non-pipelined ALU core between two valid/ready requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [OP_W-1:0]  req0_op_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_result_o,
    output logic             rsp0_flag_o,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [OP_W-1:0]  req1_op_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_result_o,
    output logic             rsp1_flag_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_done_o
);
    state_t           state, state_nx;
    logic             last_grant, owner, grant, any_req, accept, rsp_done;
    logic [WIDTH-1:0] a_q, b_q, alu_result, result_q;
    logic [OP_W-1:0]  op_q;
    logic             alu_flag, flag_q;
    logic [CNT_W-1:0] ops_done_q;

    // on a tie the requester that did not win last time gets the grant
    assign any_req      = req0_valid_i | req1_valid_i;
    assign grant        = (req0_valid_i & req1_valid_i) ? ~last_grant : req1_valid_i;
    assign req0_ready_o = (state == IDLE) & any_req & ~grant;
    assign req1_ready_o = (state == IDLE) & any_req & grant;
    assign accept       = req0_ready_o | req1_ready_o;
    assign rsp_done     = (state == RESP) & (owner ? rsp1_ready_i : rsp0_ready_i);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? EXEC : IDLE;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = rsp_done ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            flag_q     <= 1'b0;
            ops_done_q <= '0;
        end else begin
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                a_q        <= grant ? req1_a_i : req0_a_i;
                b_q        <= grant ? req1_b_i : req0_b_i;
                op_q       <= grant ? req1_op_i : req0_op_i;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                flag_q   <= alu_flag;
            end
            if (rsp_done) ops_done_q <= ops_done_q + 1'b1;
        end
    end

    alu_top u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flag   (alu_flag)
    );

    assign rsp0_valid_o  = (state == RESP) & ~owner;
    assign rsp1_valid_o  = (state == RESP) & owner;
    assign rsp0_result_o = result_q;
    assign rsp1_result_o = result_q;
    assign rsp0_flag_o   = flag_q;
    assign rsp1_flag_o   = flag_q;
    assign busy_o        = state != IDLE;
    assign ops_done_o    = ops_done_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and a random transaction-level scoreboard
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o, rsp0_valid_o, rsp0_ready_i, rsp0_flag_o;
    logic        req1_valid_i, req1_ready_o, rsp1_valid_o, rsp1_ready_i, rsp1_flag_o;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp0_result_o, rsp1_result_o;
    logic [4:0]  req0_op_i, req1_op_i;
    logic        busy_o;
    logic [15:0] ops_done_o;

    int errors = 0;
    int checks = 0;

    alu_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_result_o(rsp0_result_o), .rsp0_flag_o(rsp0_flag_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_result_o(rsp1_result_o), .rsp1_flag_o(rsp1_flag_o),
        .busy_o(busy_o), .ops_done_o(ops_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
    } vec_t;
    vec_t vecs[17];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end else begin
            req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? req0_ready_o : req1_ready_o;
    endfunction

    // {flag, result} from the operation definitions
    function automatic logic [32:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        f;
        logic [31:0] sa, sb;
        int          s;
        r = 0; f = 0; s = int'(b[4:0]);
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a + ~b + 1;
            ALU_SLL:  r = a * (32'd1 << s);
            ALU_SLTS: r = {31'd0, sa < sb};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = (a | b) & ~(a & b);
            ALU_SRL:  r = a / (32'd1 << s);
            ALU_SRA:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_EQ:   f = a == b;
            ALU_NE:   f = a != b;
            ALU_LTS:  f = sa < sb;
            ALU_GES:  f = !(sa < sb);
            ALU_LTU:  f = a < b;
            ALU_GEU:  f = !(a < b);
            default:  ;
        endcase
        return {f, r};
    endfunction

    // one complete transaction on requester k, response held off for 'hold' cycles
    task automatic run_op(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic [31:0] er, input logic ef, input string nm);
        int n;
        drive(k, 1'b1, op, a, b);
        #1;
        n = 0;
        while (!rdy(k) && n < 16) begin
            tick();
            n++;
        end
        chk({nm, "_accept"}, 32'(n < 16), 1);
        tick();
        drive(k, 1'b0, op, a, b);
        #1;
        chk({nm, "_exec_busy"}, 32'(busy_o), 1);
        chk({nm, "_exec_no_rsp"}, 32'(rsp0_valid_o | rsp1_valid_o), 0);
        tick();
        for (int h = 0; h <= hold; h++) begin
            chk({nm, "_valid"}, 32'(k == 0 ? rsp0_valid_o : rsp1_valid_o), 1);
            chk({nm, "_other_valid"}, 32'(k == 0 ? rsp1_valid_o : rsp0_valid_o), 0);
            chk({nm, "_result"}, k == 0 ? rsp0_result_o : rsp1_result_o, er);
            chk({nm, "_flag"}, 32'(k == 0 ? rsp0_flag_o : rsp1_flag_o), 32'(ef));
            chk({nm, "_rsp_readys"}, 32'(req0_ready_o | req1_ready_o), 0);
            chk({nm, "_rsp_busy"}, 32'(busy_o), 1);
            if (h == hold) begin
                if (k == 0) rsp0_ready_i = 1'b1; else rsp1_ready_i = 1'b1;
            end
            tick();
        end
        rsp0_ready_i = 1'b0;
        rsp1_ready_i = 1'b0;
        #1;
        chk({nm, "_idle"}, 32'(busy_o), 0);
    endtask

    logic        pv[2];
    logic [4:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    logic        outst, owner_m, last_m, acc0, acc1, rv, done, g, ef;
    logic [31:0] er;
    logic [15:0] cnt_m;
    int          age, nacc, last_c, n;

    initial begin
        vecs[0]  = '{ALU_ADD,  32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{ALU_XOR,  32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1'b0};
        vecs[3]  = '{ALU_SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0};
        vecs[4]  = '{ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0};
        vecs[5]  = '{ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
        vecs[6]  = '{ALU_SLTS, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[7]  = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[8]  = '{ALU_OR,   32'h0000_0F00,  32'h0000_00F0,  32'h0000_0FF0,  1'b0};
        vecs[9]  = '{ALU_AND,  32'h0000_FF00,  32'h0000_0FF0,  32'h0000_0F00,  1'b0};
        vecs[10] = '{ALU_EQ,   32'd7,          32'd7,          32'd0,          1'b1};
        vecs[11] = '{ALU_NE,   32'd7,          32'd7,          32'd0,          1'b0};
        vecs[12] = '{ALU_LTS,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[13] = '{ALU_GES,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[14] = '{ALU_LTU,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[15] = '{ALU_GEU,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[16] = '{5'b01000, 32'd1,          32'd1,          32'd0,          1'b0};

        rst_i = 1'b1;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        rsp0_ready_i = 1'b0;
        rsp1_ready_i = 1'b0;
        tick();
        tick();
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_rsp_valid", 32'(rsp0_valid_o | rsp1_valid_o), 0);
        chk("reset_result", rsp0_result_o, 0);
        chk("reset_flag", 32'(rsp0_flag_o), 0);
        chk("reset_ops_done", 32'(ops_done_o), 0);
        rst_i = 1'b0;
        drive(0, 1'b1, ALU_ADD, 1, 1);
        drive(1, 1'b1, ALU_ADD, 1, 1);
        #1;
        chk("first_tie_req0_ready", 32'(req0_ready_o), 1);
        chk("first_tie_req1_ready", 32'(req1_ready_o), 0);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        #1;
        chk("no_req_no_ready", 32'(req0_ready_o | req1_ready_o), 0);
        tick();

        for (int i = 0; i < 17; i++) begin
            run_op(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, i % 3, vecs[i].res, vecs[i].flag, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ops_done", i), 32'(ops_done_o), 32'(i + 1));
        end

        // requester 0 also waiting; requester 1 must win since 0 was served last
        drive(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        run_op(1, ALU_LTS, 32'hFFFF_FFFF, 32'd1, 4, 32'd0, 1'b1, "bp");
        run_op(0, ALU_ADD, 32'd5, 32'd7, 0, 32'd12, 1'b0, "bp_after");

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(0, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
        #1;
        chk("rstmid_ready", 32'(req0_ready_o), 1);
        tick();
        drive(0, 1'b0, 0, 0, 0);
        rsp0_ready_i = 1'b1;
        #1;
        chk("rstmid_exec", 32'(busy_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstmid_idle", 32'(busy_o), 0);
        chk("rstmid_ops_done", 32'(ops_done_o), 0);
        for (int i = 0; i < 4; i++) begin
            chk("rstmid_no_rsp", 32'(rsp0_valid_o | rsp1_valid_o), 0);
            tick();
        end
        rsp0_ready_i = 1'b0;
        drive(0, 1'b1, ALU_ADD, 1, 1);
        drive(1, 1'b1, ALU_ADD, 1, 1);
        #1;
        chk("rstmid_tie_req0", 32'(req0_ready_o), 1);
        chk("rstmid_tie_req1", 32'(req1_ready_o), 0);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(0, 1'b1, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        drive(1, 1'b1, ALU_SUB, 32'd3, 32'd5);
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        nacc = 0;
        last_c = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req0_ready_o | req1_ready_o) begin
                chk("tie_order", 32'(req1_ready_o), 32'(nacc % 2));
                if (nacc > 0) chk("tie_gap", 32'(c - last_c), 3);
                last_c = c;
                nacc++;
            end
            if (rsp0_valid_o) chk("tie_rsp0", rsp0_result_o, 32'h0000_FF00);
            if (rsp1_valid_o) chk("tie_rsp1", rsp1_result_o, 32'hFFFF_FFFE);
            tick();
        end
        chk("tie_accepts", 32'(nacc), 6);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        n = 0;
        while (busy_o && n < 10) begin
            tick();
            n++;
        end
        chk("tie_drain", 32'(busy_o), 0);
        chk("tie_ops_done", 32'(ops_done_o), 6);
        rsp0_ready_i = 1'b0;
        rsp1_ready_i = 1'b0;

        force dut.ops_done_q = 16'hFFFF;
        #1;
        release dut.ops_done_q;
        #1;
        chk("wrap_preload", 32'(ops_done_o), 32'hFFFF);
        run_op(0, ALU_ADD, 32'd1, 32'd2, 0, 32'd3, 1'b0, "wrap");
        chk("wrap_ops_done", 32'(ops_done_o), 0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        pv[0] = 0; pv[1] = 0;
        outst = 0; owner_m = 0; last_m = 1; cnt_m = 0; age = 0; er = 0; ef = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 1) == 1) begin
                    pv[k] = 1;
                    pop[k] = 5'($urandom_range(0, 31));
                    pa[k] = $urandom;
                    pb[k] = ($urandom_range(0, 3) == 0) ? pa[k] : $urandom;
                end
                drive(k, pv[k], pop[k], pa[k], pb[k]);
            end
            rsp0_ready_i = 1'($urandom_range(0, 1));
            rsp1_ready_i = 1'($urandom_range(0, 1));
            #1;
            acc0 = req0_valid_i & req0_ready_o;
            acc1 = req1_valid_i & req1_ready_o;
            rv = outst && age >= 2;
            chk("rnd_busy", 32'(busy_o), 32'(outst));
            chk("rnd_ops_done", 32'(ops_done_o), 32'(cnt_m));
            chk("rnd_rsp0_valid", 32'(rsp0_valid_o), 32'(rv && !owner_m));
            chk("rnd_rsp1_valid", 32'(rsp1_valid_o), 32'(rv && owner_m));
            done = 0;
            if (rv) begin
                chk("rnd_result", owner_m ? rsp1_result_o : rsp0_result_o, er);
                chk("rnd_flag", 32'(owner_m ? rsp1_flag_o : rsp0_flag_o), 32'(ef));
                done = owner_m ? rsp1_ready_i : rsp0_ready_i;
            end
            chk("rnd_one_grant", 32'(acc0 & acc1), 0);
            if (outst) chk("rnd_hold_off", 32'(acc0 | acc1), 0);
            else if (pv[0] | pv[1]) chk("rnd_grant", 32'(acc0 | acc1), 1);
            if (pv[0] && pv[1] && (acc0 | acc1)) chk("rnd_fair", 32'(acc1), 32'(!last_m));
            g = acc1;
            if ((acc0 | acc1) && !outst) begin
                last_m = g;
                owner_m = g;
                {ef, er} = alu_ref(pop[g], pa[g], pb[g]);
                pv[g] = 0;
                age = 0;
            end
            tick();
            if (done) begin
                outst = 0;
                cnt_m++;
            end
            if ((acc0 | acc1) && !outst) outst = 1;
            if (outst) age++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
